// File: rtl/sensor_frame_tx.sv
// Sensor sample / alarm framer with an 8N1 UART transmitter: each frame is two checked bytes.
// Optional statistics outputs are enabled with `define SENSOR_FRAME_TX_STATS_EN.
module sensor_frame_tx #(
  parameter int          CLK_HZ     = 50000000,
  parameter int          BAUD       = 115200,
  parameter logic [7:0]  KEY        = 8'h37,
  parameter logic [7:0]  ALARM_MARK = 8'hFF,
  parameter int          GAP_BITS   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sample,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        alarm_req,
  output logic        tx,
  output logic        busy,
  output logic        dropped
`ifdef SENSOR_FRAME_TX_STATS_EN
  ,
  output logic [15:0] frames_sent,
  output logic [7:0]  drop_count
`endif
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] GAP_LAST = (GAP_BITS == 0) ? 4'd0 : 4'(GAP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t         state_reg;
  logic [CW-1:0]  baud_cnt_reg;
  logic [2:0]     bit_idx_reg;
  logic [3:0]     gap_cnt_reg;
  logic           byte_sel_reg;
  logic [7:0]     shift_reg;
  logic [7:0]     byte1_reg;
  logic           alarm_pending_reg;
  logic           tx_reg;
  logic           dropped_reg;

  logic bit_end;
  logic accept;
  logic drop_hit;
  logic byte_done;

  assign sample_ready = !reset && (state_reg == IDLE) && !alarm_pending_reg && !alarm_req;
  assign accept       = sample_valid && sample_ready;
  // Zero bytes are invisible to the receiver, so neither 0 nor KEY can form a valid frame.
  assign drop_hit     = accept && ((sample == 8'h00) || (sample == KEY));
  assign bit_end      = (baud_cnt_reg == BAUD_LAST);
  assign byte_done    = bit_end && (((state_reg == STOP) && (GAP_BITS == 0)) ||
                                    ((state_reg == GAP) && (gap_cnt_reg == GAP_LAST)));

  assign tx      = tx_reg;
  assign busy    = (state_reg != IDLE) || alarm_pending_reg;
  assign dropped = dropped_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg         <= IDLE;
      baud_cnt_reg      <= '0;
      bit_idx_reg       <= '0;
      gap_cnt_reg       <= '0;
      byte_sel_reg      <= 1'b0;
      shift_reg         <= '0;
      byte1_reg         <= '0;
      alarm_pending_reg <= 1'b0;
      tx_reg            <= 1'b1;
      dropped_reg       <= 1'b0;
`ifdef SENSOR_FRAME_TX_STATS_EN
      frames_sent       <= '0;
      drop_count        <= '0;
`endif
    end else begin
      dropped_reg <= drop_hit;
`ifdef SENSOR_FRAME_TX_STATS_EN
      if (drop_hit && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
`endif
      // Pulses arriving while an alarm is pending (including the load cycle) merge into it.
      if ((state_reg == IDLE) && alarm_pending_reg)
        alarm_pending_reg <= 1'b0;
      else if (alarm_req)
        alarm_pending_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          if (alarm_pending_reg) begin
            state_reg    <= START;
            shift_reg    <= ALARM_MARK;
            byte1_reg    <= KEY;
            byte_sel_reg <= 1'b0;
            tx_reg       <= 1'b0;
          end else if (accept && !drop_hit) begin
            state_reg    <= START;
            shift_reg    <= sample;
            byte1_reg    <= sample ^ KEY;
            byte_sel_reg <= 1'b0;
            tx_reg       <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= DATA;
            bit_idx_reg  <= '0;
            tx_reg       <= shift_reg[0];
            shift_reg    <= shift_reg >> 1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              state_reg <= STOP;
              tx_reg    <= 1'b1;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            state_reg    <= GAP;
            gap_cnt_reg  <= '0;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        GAP: begin
          if (bit_end) begin
            baud_cnt_reg <= '0;
            gap_cnt_reg  <= gap_cnt_reg + 4'd1;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
        end
      endcase

      // End of a byte's trailing idle overrides the per-state transition above.
      if (byte_done) begin
        if (!byte_sel_reg) begin
          byte_sel_reg <= 1'b1;
          state_reg    <= START;
          shift_reg    <= byte1_reg;
          tx_reg       <= 1'b0;
        end else begin
          state_reg <= IDLE;
`ifdef SENSOR_FRAME_TX_STATS_EN
          frames_sent <= frames_sent + 16'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Directed bench for sensor_frame_tx: cycle-exact frame waveforms, alarm priority, drops and reset.
module tb_sensor_frame_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample = 8'h00;
  logic       sample_valid = 1'b0;
  logic       alarm_req = 1'b0;
  logic       sample_ready;
  logic       tx;
  logic       busy;
  logic       dropped;
`ifdef SENSOR_FRAME_TX_STATS_EN
  logic [15:0] frames_sent;
  logic [7:0]  drop_count;
`endif

  int total = 0;
  int bad = 0;

  sensor_frame_tx #(
    .CLK_HZ(1000),
    .BAUD(100),
    .GAP_BITS(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample(sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .alarm_req(alarm_req),
    .tx(tx),
    .busy(busy),
    .dropped(dropped)
`ifdef SENSOR_FRAME_TX_STATS_EN
    ,
    .frames_sent(frames_sent),
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called one step after the edge that starts the frame; returns one step after it ends.
  task automatic frame(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    logic [119:0] obs0, obs1, exp0, exp1;
    logic [7:0] bv;
    int slot;
    int busy_n;
    int ready_n;
    busy_n = 0;
    ready_n = 0;
    obs0 = '0;
    obs1 = '0;
    for (int k = 0; k < 120; k++) begin
      slot = k / 10;
      bv = b0;
      exp0[k] = (slot == 0) ? 1'b0 : (slot <= 8) ? bv[slot-1] : 1'b1;
      bv = b1;
      exp1[k] = (slot == 0) ? 1'b0 : (slot <= 8) ? bv[slot-1] : 1'b1;
    end
    for (int k = 0; k < 240; k++) begin
      if (k < 120) obs0[k] = tx;
      else         obs1[k-120] = tx;
      busy_n += int'(busy);
      ready_n += int'(sample_ready);
      if (k < 239) tick();
    end
    chk({tag, ".byte0"}, obs0, exp0);
    chk({tag, ".byte1"}, obs1, exp1);
    chk({tag, ".busy_cycles"}, 128'(busy_n), 128'd240);
    chk({tag, ".ready_during"}, 128'(ready_n), 128'd0);
    tick();
    chk({tag, ".busy_after"}, 128'(busy), 128'd0);
    chk({tag, ".ready_after"}, 128'(sample_ready), 128'd1);
    chk({tag, ".tx_after"}, 128'(tx), 128'd1);
    $display("txn %s frame %02h %02h", tag, b0, b1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst.tx", 128'(tx), 128'd1);
    chk("rst.ready", 128'(sample_ready), 128'd0);
    chk("rst.busy", 128'(busy), 128'd0);
    chk("rst.dropped", 128'(dropped), 128'd0);
`ifdef SENSOR_FRAME_TX_STATS_EN
    chk("rst.frames_sent", 128'(frames_sent), 128'd0);
    chk("rst.drop_count", 128'(drop_count), 128'd0);
`endif
    reset = 1'b0;
    tick();
    chk("idle.ready", 128'(sample_ready), 128'd1);
    chk("idle.tx", 128'(tx), 128'd1);

    // Plain sample frame
    sample = 8'h5A;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    frame("sample", 8'h5A, 8'h6D);

    // Alarm frame
    alarm_req = 1'b1;
    #1;
    chk("alarm.ready_pulse", 128'(sample_ready), 128'd0);
    tick();
    alarm_req = 1'b0;
    chk("alarm.ready_pend", 128'(sample_ready), 128'd0);
    chk("alarm.busy_pend", 128'(busy), 128'd1);
    chk("alarm.tx_pend", 128'(tx), 128'd1);
    tick();
    frame("alarm", 8'hFF, 8'h37);

    // Alarm and sample in the same cycle: alarm first, held sample afterwards
    alarm_req = 1'b1;
    sample = 8'h21;
    sample_valid = 1'b1;
    #1;
    chk("prio.ready_pulse", 128'(sample_ready), 128'd0);
    tick();
    alarm_req = 1'b0;
    chk("prio.ready_pend", 128'(sample_ready), 128'd0);
    tick();
    frame("prio_alarm", 8'hFF, 8'h37);
    tick();
    sample_valid = 1'b0;
    frame("prio_sample", 8'h21, 8'h16);

    // Untransmittable samples are dropped
    sample = 8'h00;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("drop0.pulse", 128'(dropped), 128'd1);
    chk("drop0.tx", 128'(tx), 128'd1);
    chk("drop0.busy", 128'(busy), 128'd0);
    chk("drop0.ready", 128'(sample_ready), 128'd1);
    tick();
    chk("drop0.pulse_end", 128'(dropped), 128'd0);
    chk("drop0.tx_end", 128'(tx), 128'd1);
    $display("txn drop sample 00");
    sample = 8'h37;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("dropkey.pulse", 128'(dropped), 128'd1);
    chk("dropkey.tx", 128'(tx), 128'd1);
    tick();
    chk("dropkey.pulse_end", 128'(dropped), 128'd0);
    chk("dropkey.tx_end", 128'(tx), 128'd1);
    chk("dropkey.busy_end", 128'(busy), 128'd0);
    $display("txn drop sample 37");
`ifdef SENSOR_FRAME_TX_STATS_EN
    chk("stats.drop_count", 128'(drop_count), 128'd2);
    chk("stats.frames_sent4", 128'(frames_sent), 128'd4);
`endif

    // Reset in the middle of bit 3 of byte0 (0x52 has bit 3 low)
    sample = 8'h52;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (42) tick();
    chk("midrst.bit3", 128'(tx), 128'd0);
    reset = 1'b1;
    tick();
    chk("midrst.tx", 128'(tx), 128'd1);
    chk("midrst.busy", 128'(busy), 128'd0);
    chk("midrst.ready", 128'(sample_ready), 128'd0);
`ifdef SENSOR_FRAME_TX_STATS_EN
    chk("midrst.frames_sent", 128'(frames_sent), 128'd0);
    chk("midrst.drop_count", 128'(drop_count), 128'd0);
`endif
    reset = 1'b0;
    #1;
    chk("midrst.ready_rel", 128'(sample_ready), 128'd1);
    $display("txn reset mid-frame");
    sample = 8'h01;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    frame("after_reset", 8'h01, 8'h36);

`ifdef SENSOR_FRAME_TX_STATS_EN
    chk("stats.frames_sent1", 128'(frames_sent), 128'd1);
    force dut.frames_sent = 16'hFFFF;
    tick();
    release dut.frames_sent;
    chk("wrap.preset", 128'(frames_sent), 128'hFFFF);
    sample = 8'h11;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    frame("wrap", 8'h11, 8'h26);
    chk("wrap.frames_sent", 128'(frames_sent), 128'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sensor_frame_tx.md
Name: sensor_frame_tx

Overview:
- Sensor-node framer and UART transmitter; the upstream counterpart of the frame-checking receiver on the board.
- Accepts 8-bit sensor samples and alarm requests.
- Sends each sample as a two-byte checked frame over an 8N1 serial line: data byte, then data XOR KEY.
- Sends an alarm as the frame ALARM_MARK, KEY; the receiver decodes this as a zero result.

Parameters:
- CLK_HZ, 50000000, clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division, must be >= 2.
- KEY, 8'h37, frame check key; must match the receiver's key.
- ALARM_MARK, 8'hFF, first byte of an alarm frame.
- GAP_BITS, 2, idle-high bit times inserted after each stop bit, 0..15.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- sample, in, 8, sensor value.
- sample_valid, in, 1, sample offered.
- sample_ready, out, 1, block can accept a sample this cycle.
- alarm_req, in, 1, single-cycle alarm request pulse.
- tx, out, 1, serial output; idle high.
- busy, out, 1, a frame is in progress or an alarm is pending.
- dropped, out, 1, one-cycle pulse when an accepted sample is discarded.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk. All logic is on posedge clk.
- Reset values: tx=1, sample_ready=0, busy=0, dropped=0. alarm_pending and all counters clear to 0. FSM goes to IDLE.
- Reset mid-frame: tx returns high the cycle after reset is sampled. The partial byte is abandoned and no resume occurs.
- alarm_req sets alarm_pending. alarm_pending holds until an alarm frame is loaded. Further pulses while pending are merged.
- sample_ready = (state==IDLE) && !alarm_pending && !alarm_req, combinational. A transfer occurs when sample_valid && sample_ready.
- Alarm priority: if alarm_req and sample_valid arrive in the same IDLE cycle, the sample is not accepted and the alarm is sent first.
- Drop rule: an accepted sample equal to 8'h00 or equal to KEY cannot be transmitted, because the receiver ignores zero bytes.
  - The sample is consumed and dropped pulses the next cycle.
  - The FSM stays in IDLE and nothing is sent.
- Frame load: byte0/byte1 are registered at acceptance.
  - Sample frame: byte0=sample, byte1=sample^KEY.
  - Alarm frame: byte0=ALARM_MARK, byte1=KEY.
- FSM states: IDLE, START, DATA, STOP, GAP.
  - IDLE -> START on accepted valid sample, or when alarm_pending is set. byte_sel=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each, bit index 0..7, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then GAP. If GAP_BITS==0, go directly to the next step.
  - GAP: tx=1 for GAP_BITS*CLKS_PER_BIT cycles.
  - After STOP/GAP: if byte_sel==0, set byte_sel=1 and go to START. Otherwise go to IDLE.
- Latency: tx falls on the first edge after the acceptance cycle. The frame occupies exactly 2*(10+GAP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: sample_ready may assert in the first IDLE cycle after the frame ends. There is no extra idle beyond GAP.
- busy = (state!=IDLE) || alarm_pending.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps. It restarts at 0 on every state entry.

Optional Feature:
- Macro SENSOR_FRAME_TX_STATS_EN.
- Defined: adds output frames_sent[15:0] and output drop_count[7:0].
  - frames_sent increments when the final stop/gap of byte1 completes. It counts alarm and sample frames and wraps at 16'hFFFF -> 0.
  - drop_count increments with each dropped pulse and saturates at 8'hFF.
  - Both reset to 0.
- Undefined: neither port nor register exists; all other behaviour is identical.

Test Plan:
Bench parameters: CLK_HZ=1000, BAUD=100, so CLKS_PER_BIT=10; GAP_BITS=2.
- Sample path: sample=8'h5A, valid for 1 cycle -> tx carries 0x5A then 0x6D, LSB first, 8N1. busy stays high for exactly 240 cycles, then sample_ready=1.
- Alarm path: alarm_req pulse while IDLE -> frame 0xFF, 0x37 is sent. sample_ready is 0 from the pulse cycle until the frame ends.
- Alarm priority: alarm_req and valid sample 8'h21 in the same cycle -> 0xFF, 0x37 is sent first. The sample is held by the source and then sent as 0x21, 0x16.
- Drop cases: sample 8'h00, then 8'h37 -> two dropped pulses, tx stays 1 throughout, and drop_count=2 when STATS_EN is defined.
- Reset mid-frame: reset during bit 3 of byte0 -> tx=1 one cycle later, busy=0, and the next sample 8'h01 is sent cleanly as 0x01, 0x36.
- Counter wrap (STATS_EN): force frames_sent=16'hFFFF, send one frame -> frames_sent=0.
